btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input-conditioning stage directly upstream of the VGA/game top.
- Takes raw asynchronous board buttons and produces per-button debounced level, press pulse and release pulse, all synchronous to clk.
- Level outputs drive the top's stepleft/stepright/stepjump/buttondown inputs.
- Press pulses serve single-shot consumers, e.g. one jump per press.

Parameters:
- N_BTN, 4, number of button channels; bit i is channel i.
- DEBOUNCE_CYCLES, 650000, consecutive stable synchronized cycles required to accept a new level (10 ms at 65 MHz); legal range 2..2^24.
- REPEAT_DELAY, 26000000, cycles held before the first auto-repeat pulse (only with the optional feature).
- REPEAT_PERIOD, 6500000, cycles between subsequent auto-repeat pulses (only with the optional feature).

Ports:
- clk  input  1  system/pixel clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_raw  input  N_BTN  raw, unsynchronized, bouncing button pins.
- btn_level  output  N_BTN  debounced level per channel.
- btn_press  output  N_BTN  one-cycle pulse on an accepted 0->1 transition (plus repeats when enabled).
- btn_release  output  N_BTN  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Reset (rst=0, asynchronous): synchronizer flops, counters and all outputs go to 0 and all channels enter S_LOW. Outputs stay 0 while rst=0. Deassertion takes effect on the next clk edge.
- Synchronizer: 2-flop chain per bit. sync[i] lags btn_raw[i] by 2 cycles. No combinational path from btn_raw to any output.
- Per-channel FSM, channels independent, counter width clog2(DEBOUNCE_CYCLES+1):
  - S_LOW: cnt=0. If sync=1 -> S_RISE with cnt=1.
  - S_RISE: if sync=0 -> S_LOW, cnt=0 (bounce rejected). Else if cnt=DEBOUNCE_CYCLES-1 -> S_HIGH, registered btn_level=1, btn_press=1 for that one cycle. Else cnt+1.
  - S_HIGH: cnt=0. If sync=0 -> S_FALL with cnt=1.
  - S_FALL: mirror of S_RISE. Exit to S_HIGH on sync=1. On reaching the threshold -> S_LOW, btn_level=0, btn_release=1 for one cycle.
- Latency: a clean edge on btn_raw at cycle 0 gives btn_level change and pulse at cycle 2+DEBOUNCE_CYCLES.
- The pulse cycle equals the first cycle of the new btn_level value.
- btn_press and btn_release are never asserted in the same cycle on one channel.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output activity.
- Simultaneous transitions on multiple channels are handled independently and may pulse in the same cycle.
- Counters never wrap: the threshold compare exits before overflow.
- Reset mid-count discards the partial count. After reset, a button held high requires a full DEBOUNCE_CYCLES to be accepted, then produces a press pulse.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: each channel has a repeat counter, cleared on entry to S_HIGH. While in S_HIGH, an extra one-cycle btn_press is issued REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles. Any exit from S_HIGH (entry to S_FALL) clears the repeat counter. btn_level is unaffected.
- Undefined: no repeat counters are instantiated; exactly one btn_press per accepted press. REPEAT_* parameters are ignored.

Test Plan:
- Clean press, bench with DEBOUNCE_CYCLES=8: btn_raw[0] 0->1 at cycle 0 and held -> btn_level[0]=1 and btn_press[0]=1 at cycle 10 only; btn_press[0]=0 at cycle 11.
- Bounce rejection, DEBOUNCE_CYCLES=8: btn_raw[1] toggles high 5 cycles / low 2 cycles three times, then held high -> no pulses during bouncing; a single btn_press[1] 10 cycles after the final rising edge.
- Release, DEBOUNCE_CYCLES=8: held channel 2 drops to 0 -> btn_level[2]=0 and btn_release[2]=1 exactly 10 cycles later; btn_press[2] stays 0 throughout.
- Async reset mid-count: rst=0 asserted at cycle 6 of a count, asynchronously between clock edges -> all outputs 0 immediately. rst=1 with button still held -> press pulse exactly 2+8 cycles after the first active edge, i.e. the partial count is lost.
- Multi-channel simultaneous: channels 0 and 3 rise in the same cycle -> both btn_press bits pulse in the same cycle (cycle 10); channels 1 and 2 stay 0.
- BTN_AUTOREPEAT_EN defined, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold channel 0 for 40 cycles -> btn_press[0] pulses at cycles 10, 30, 35, 40. Release stops repeats; btn_release[0] pulses once.

Source files
------------

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//    Conditions raw, asynchronous, bouncing board buttons into clean signals
//    synchronous to clk. Each channel gets a debounced level, a one-cycle
//    press pulse on an accepted rising transition and a one-cycle release
//    pulse on an accepted falling transition. The level outputs feed the
//    game top's step/jump/button inputs; the press pulses serve single-shot
//    consumers such as "one jump per press".
//
// Ports:
//    clk          in   1      system/pixel clock, rising edge
//    rst          in   1      asynchronous reset, active low (0 = in reset)
//    btn_raw      in   N_BTN  raw button pins, unsynchronized and bouncing
//    btn_level    out  N_BTN  debounced level per channel (registered)
//    btn_press    out  N_BTN  one-cycle pulse on accepted 0->1 (registered)
//    btn_release  out  N_BTN  one-cycle pulse on accepted 1->0 (registered)
//
// Parameters:
//    N_BTN            number of channels, bit i is channel i
//    DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to
//                     accept a new level (legal range 2 .. 2^24)
//    REPEAT_DELAY     cycles held before the first auto-repeat press
//    REPEAT_PERIOD    cycles between later auto-repeat presses
//
// Build option:
//    BTN_AUTOREPEAT_EN  when defined, a held button issues extra press
//                       pulses REPEAT_DELAY cycles after the initial press
//                       and then every REPEAT_PERIOD cycles. When undefined
//                       there is exactly one press per accepted press and
//                       the REPEAT_* parameters have no effect.
//
// Latency: a clean edge on btn_raw in cycle 0 changes btn_level and fires
// the matching pulse in cycle 2 + DEBOUNCE_CYCLES; the pulse cycle is the
// first cycle of the new level.
// ---------------------------------------------------------------------------
module btn_conditioner #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int REPEAT_DELAY    = 26000000,
   parameter int REPEAT_PERIOD   = 6500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Per-channel debounce states. RISE/FALL are the "candidate" states in
   // which the counter measures how long the new value has been stable.
   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_e;

   logic [N_BTN-1:0] sync1_q, sync1_d;
   logic [N_BTN-1:0] sync2_q, sync2_d;

   state_e           state_q [N_BTN];
   state_e           state_d [N_BTN];
   logic [CNT_W-1:0] cnt_q   [N_BTN];
   logic [CNT_W-1:0] cnt_d   [N_BTN];

   logic [N_BTN-1:0] btn_level_q,   btn_level_d;
   logic [N_BTN-1:0] btn_press_q,   btn_press_d;
   logic [N_BTN-1:0] btn_release_q, btn_release_d;

   // Extra press requests from the auto-repeat logic (all zero when the
   // feature is not built).
   logic [N_BTN-1:0] rep_fire;

   // Two-flop synchronizer chain: the first stage may go metastable, the
   // second stage is the only value the debounce FSMs ever look at.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // Debounce next-state logic. A candidate state returns to its origin on
   // the first disagreeing sample, so any glitch shorter than the threshold
   // leaves no trace. The threshold compare exits before the counter could
   // ever wrap.
   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = '0;
         case (state_q[i])
            S_LOW: begin
               if (sync2_q[i]) begin
                  state_d[i] = S_RISE;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            S_RISE: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_LOW;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = S_HIGH;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_FALL;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            S_FALL: begin
               if (sync2_q[i]) begin
                  state_d[i] = S_HIGH;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = S_LOW;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = S_LOW;
            end
         endcase
      end
   end

   // Output decode. The level follows the accepted side of the FSM (a
   // candidate state still reports the old level), and the pulses mark the
   // exact transitions out of a candidate state on acceptance, so a press
   // and a release can never coincide on one channel.
   always_comb begin
      btn_level_d   = '0;
      btn_press_d   = '0;
      btn_release_d = '0;
      for (int i = 0; i < N_BTN; i++) begin
         btn_level_d[i]   = (state_d[i] == S_HIGH) || (state_d[i] == S_FALL);
         btn_press_d[i]   = ((state_q[i] == S_RISE) && (state_d[i] == S_HIGH))
                            || rep_fire[i];
         btn_release_d[i] = (state_q[i] == S_FALL) && (state_d[i] == S_LOW);
      end
   end

   // State, counter, synchronizer and output registers. Reset is
   // asynchronous so the outputs drop immediately and any partial count is
   // discarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         btn_level_q   <= '0;
         btn_press_q   <= '0;
         btn_release_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= S_LOW;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         btn_level_q   <= btn_level_d;
         btn_press_q   <= btn_press_d;
         btn_release_q <= btn_release_d;
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
   localparam logic [REP_W-1:0] REP_BASE  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_cnt_q [N_BTN];
   logic [REP_W-1:0] rep_cnt_d [N_BTN];

   // Repeat timer. It only runs while a channel stays in S_HIGH; every other
   // state (including the edge that enters S_HIGH) holds it at zero. After
   // the first repeat the counter is parked at REPEAT_DELAY so the later
   // repeats are spaced by REPEAT_PERIOD using the same counter.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < N_BTN; i++) begin
         rep_cnt_d[i] = '0;
         if ((state_q[i] == S_HIGH) && (state_d[i] == S_HIGH)) begin
            if ((rep_cnt_q[i] == REP_FIRST) || (rep_cnt_q[i] == REP_NEXT)) begin
               rep_fire[i]  = 1'b1;
               rep_cnt_d[i] = REP_BASE;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + REP_ONE;
            end
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_BTN; i++) begin
            rep_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            rep_cnt_q[i] <= rep_cnt_d[i];
         end
      end
   end
`else
   // Without auto-repeat there are no repeat timers and no extra presses;
   // the repeat settings are only folded into a deliberately unused net.
   logic repeat_cfg_unused;
   assign repeat_cfg_unused = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
   assign rep_fire          = '0;
`endif

   assign btn_level   = btn_level_q;
   assign btn_press   = btn_press_q;
   assign btn_release = btn_release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Drives btn_conditioner (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=5) with directed scenarios followed by random bouncing
// inputs and random async resets. Every cycle the outputs are compared
// against a reference model that decides acceptance from the history of
// synchronized samples: a new level is accepted at the edge where the last
// DEBOUNCE_CYCLES samples seen by the channel all disagree with the current
// level. Inputs change 1 time unit after a rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

   localparam int NB   = 4;
   localparam int DEB  = 8;
   localparam int RDLY = 20;
   localparam int RPER = 5;
   localparam int LOGN = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NB-1:0] btnRaw = '0;
   logic [NB-1:0] btnLevel;
   logic [NB-1:0] btnPress;
   logic [NB-1:0] btnRelease;

   int checks = 0;
   int errors = 0;
   int tcur   = 0;

   // rawLog[c] is the raw value present during cycle c, or 0 if that cycle
   // was spent in reset (such a sample never reaches the debounce logic).
   logic [NB-1:0] rawLog [LOGN];
   logic [NB-1:0] mLevel   = '0;
   logic [NB-1:0] mPress   = '0;
   logic [NB-1:0] mRelease = '0;
   int            refEdge [NB];

   btn_conditioner #(
      .N_BTN          (NB),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RDLY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btnRaw),
      .btn_level  (btnLevel),
      .btn_press  (btnPress),
      .btn_release(btnRelease)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // The sample the channel's debounce logic looks at on edge t: the raw
   // value of cycle t-3 (two synchronizer stages plus the capture edge).
   function automatic logic seenAt(input int t, input int ch);
      if (t < 0) return 1'b0;
      return rawLog[t][ch];
   endfunction

   task automatic modelReset();
      mLevel   = '0;
      mPress   = '0;
      mRelease = '0;
      for (int j = 0; j <= tcur && j < LOGN; j++) rawLog[j] = '0;
   endtask

   // Reference model for one rising edge t.
   task automatic modelEdge(input int t);
      mPress   = '0;
      mRelease = '0;
      if (rst !== 1'b1) return;
      for (int ch = 0; ch < NB; ch++) begin
         logic want;
         bit   stable;
         want   = ~mLevel[ch];
         stable = 1'b1;
         for (int k = 0; k < DEB; k++) begin
            if (seenAt(t - 3 - k, ch) !== want) stable = 1'b0;
         end
         if (stable) begin
            mLevel[ch] = want;
            if (want) begin
               mPress[ch]   = 1'b1;
               refEdge[ch]  = t;
            end else begin
               mRelease[ch] = 1'b1;
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         else if (mLevel[ch] && seenAt(t - 3, ch)) begin
            if (!seenAt(t - 4, ch)) begin
               refEdge[ch] = t;
            end else if ((t - refEdge[ch]) >= RDLY &&
                         ((t - refEdge[ch] - RDLY) % RPER) == 0) begin
               mPress[ch] = 1'b1;
            end
         end
`endif
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h",
                tag, tcur, obs, exp);
      end
   endtask

   // Drive inputs for the current cycle; asserting reset clears the model
   // at once since the DUT reset is asynchronous.
   task automatic applyStimulus(input logic [NB-1:0] raw, input logic rstv);
      btnRaw = raw;
      if (rstv === 1'b0 && rst === 1'b1) begin
         rst = 1'b0;
         modelReset();
      end else begin
         rst = rstv;
      end
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      rawLog[tcur] = (rst === 1'b1) ? btnRaw : '0;
      checkOutput("model_level",   btnLevel,   mLevel);
      checkOutput("model_press",   btnPress,   mPress);
      checkOutput("model_release", btnRelease, mRelease);
   endtask

   task automatic advance();
      @(posedge clk);
      modelEdge(tcur + 1);
      tcur++;
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) begin
         sampleCycle();
         advance();
      end
   endtask

   initial begin
      int pressCount;
      int relCount;
      logic [NB-1:0] rnd;
      int rstHold;

      for (int j = 0; j < LOGN; j++) rawLog[j] = '0;
      for (int ch = 0; ch < NB; ch++) refEdge[ch] = 0;
      $display("[TB] btn_conditioner bench, DEBOUNCE_CYCLES=%0d", DEB);

      // Reset state, including a raw input that must not leak through.
      @(posedge clk);
      #1;
      applyStimulus(4'b1111, 1'b0);
      runCycles(3);
      checkOutput("reset_level",   btnLevel,   0);
      checkOutput("reset_press",   btnPress,   0);
      checkOutput("reset_release", btnRelease, 0);
      applyStimulus(4'b0000, 1'b1);
      runCycles(6);

      // Clean press on channel 0.
      applyStimulus(4'b0001, 1'b1);
      for (int c = 0; c <= 12; c++) begin
         sampleCycle();
         if (c == 9)  checkOutput("clean_press_c9",  btnPress[0], 0);
         if (c == 10) begin
            checkOutput("clean_press_c10", btnPress,    4'b0001);
            checkOutput("clean_level_c10", btnLevel[0], 1);
         end
         if (c == 11) checkOutput("clean_press_c11", btnPress[0], 0);
         advance();
      end

      // Bounce on channel 1: high 5 / low 2 three times, then held.
      pressCount = 0;
      for (int c = 0; c <= 34; c++) begin
         applyStimulus({2'b00, (c >= 21) || ((c % 7) < 5), 1'b1}, 1'b1);
         sampleCycle();
         if (btnPress[1] === 1'b1) pressCount++;
         if (c == 30) checkOutput("bounce_press_c30", btnPress[1], 0);
         if (c == 31) checkOutput("bounce_press_c31", btnPress[1], 1);
         advance();
      end
      checkOutput("bounce_press_count", pressCount, 1);

      // Release on channel 2.
      applyStimulus(4'b0111, 1'b1);
      runCycles(12);
      applyStimulus(4'b0011, 1'b1);
      pressCount = 0;
      for (int c = 0; c <= 12; c++) begin
         sampleCycle();
         if (btnPress[2] === 1'b1) pressCount++;
         if (c == 9)  checkOutput("release_c9",  btnRelease, 4'b0000);
         if (c == 10) begin
            checkOutput("release_c10",       btnRelease,  4'b0100);
            checkOutput("release_level_c10", btnLevel[2], 0);
         end
         advance();
      end
      checkOutput("release_no_press", pressCount, 0);

      // Async reset mid-count: ch3 accepted high, ch0 counting when reset hits.
      applyStimulus(4'b1000, 1'b1);
      runCycles(14);
      checkOutput("pre_reset_level", btnLevel, 4'b1000);
      applyStimulus(4'b1001, 1'b1);
      runCycles(6);
      #2;
      applyStimulus(4'b1001, 1'b0);
      #1;
      checkOutput("async_reset_level", btnLevel, 0);
      checkOutput("async_reset_press", btnPress, 0);
      runCycles(3);
      applyStimulus(4'b1001, 1'b1);
      for (int c = 0; c <= 12; c++) begin
         sampleCycle();
         if (c == 9)  checkOutput("post_reset_press_c9", btnPress, 4'b0000);
         if (c == 10) begin
            checkOutput("post_reset_press_c10", btnPress, 4'b1001);
            checkOutput("post_reset_level_c10", btnLevel, 4'b1001);
         end
         advance();
      end

      // Simultaneous rise on channels 0 and 3.
      applyStimulus(4'b0000, 1'b1);
      runCycles(14);
      applyStimulus(4'b1001, 1'b1);
      for (int c = 0; c <= 12; c++) begin
         sampleCycle();
         if (c == 10) begin
            checkOutput("multi_press_c10", btnPress, 4'b1001);
            checkOutput("multi_level_c10", btnLevel, 4'b1001);
         end
         advance();
      end
      applyStimulus(4'b0000, 1'b1);
      runCycles(14);

`ifdef BTN_AUTOREPEAT_EN
      // Auto-repeat: hold channel 0 for 40 cycles.
      pressCount = 0;
      relCount   = 0;
      for (int c = 0; c <= 60; c++) begin
         applyStimulus((c < 40) ? 4'b0001 : 4'b0000, 1'b1);
         sampleCycle();
         if (btnPress[0] === 1'b1) pressCount++;
         if (btnRelease[0] === 1'b1) relCount++;
         if (c == 10 || c == 30 || c == 35 || c == 40)
            checkOutput("repeat_press", btnPress[0], 1);
         advance();
      end
      checkOutput("repeat_press_count",   pressCount, 4);
      checkOutput("repeat_release_count", relCount,   1);
`endif

      // Random bouncing with alternating noisy/quiet phases and rare resets.
      rnd     = '0;
      rstHold = 0;
      relCount = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int ch = 0; ch < NB; ch++) begin
            if ((((c / 250) % 2) == 0) ? ($urandom_range(0, 5) == 0)
                                       : ($urandom_range(0, 24) == 0))
               rnd[ch] = ~rnd[ch];
         end
         if (rstHold > 0) begin
            rstHold--;
            applyStimulus(rnd, (rstHold == 0) ? 1'b1 : 1'b0);
         end else if ($urandom_range(0, 499) == 0) begin
            rstHold = 3;
            applyStimulus(rnd, 1'b0);
         end else begin
            applyStimulus(rnd, 1'b1);
         end
         sampleCycle();
         if (btnRelease !== 4'b0000) relCount++;
         advance();
      end
      checkOutput("random_saw_releases", (relCount > 0) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
